// File: rtl/pulse_detector.sv
// pulse_detector: tracks the ADC background with an IIR baseline and detects
// pulses above baseline + threshold. Each pulse becomes one event record
// (peak, width, timestamp) in a single-entry valid/ready output register,
// with accepted-event and dropped-event counters.
module pulse_detector #(
  parameter int                   ADC_WIDTH      = 12,
  parameter int                   BASELINE_SHIFT = 4,
  parameter logic [ADC_WIDTH-1:0] BASELINE_INIT  = 12'd2048,
  parameter int                   HOLDOFF_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADC_WIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic [ADC_WIDTH-1:0] threshold,
  input  logic                 clear_counts,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [ADC_WIDTH-1:0] event_peak,
  output logic [15:0]          event_width,
  output logic [31:0]          event_timestamp,
  output logic [31:0]          event_count,
  output logic [15:0]          drop_count,
  output logic [ADC_WIDTH-1:0] baseline_out
);

  localparam int                ACC_W     = ADC_WIDTH + BASELINE_SHIFT;
  localparam logic [ACC_W-1:0]  ACC_INIT  = {BASELINE_INIT, {BASELINE_SHIFT{1'b0}}};
  localparam logic [15:0]       HOLD_LOAD = 16'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_HOLD
  } state_t;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [ADC_WIDTH-1:0] max_adc(input logic [ADC_WIDTH-1:0] a,
                                                   input logic [ADC_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                 state_q;
  logic [ACC_W-1:0]       acc_q;
  logic [ACC_W-1:0]       acc_d;
  logic [31:0]            sample_idx_q;
  logic [ADC_WIDTH-1:0]   peak_q;
  logic [15:0]            width_q;
  logic [31:0]            ts_q;
  logic [ADC_WIDTH-1:0]   base_l_q;
  logic [15:0]            hold_q;
  logic                   emit_q;

  logic                   ev_valid_q;
  logic [ADC_WIDTH-1:0]   ev_peak_q;
  logic [15:0]            ev_width_q;
  logic [31:0]            ev_ts_q;
  logic [31:0]            ev_count_q;
  logic [15:0]            drop_q;

  logic [ADC_WIDTH-1:0]   baseline;
  logic [ADC_WIDTH:0]     lvl;
  logic                   above;

  // Baseline, trigger level and the next IIR accumulator value. acc never
  // exceeds (2^ADC_WIDTH-1)<<SHIFT, so the update fits in ACC_W bits and
  // acc - baseline cannot go negative.
  always_comb begin
    baseline = acc_q[ACC_W-1:BASELINE_SHIFT];
    lvl      = {1'b0, baseline} + {1'b0, threshold};
    above    = ({1'b0, sample_in} > lvl);
    acc_d    = acc_q - {{BASELINE_SHIFT{1'b0}}, baseline}
                     + {{BASELINE_SHIFT{1'b0}}, sample_in};
  end

  // Detection FSM, baseline filter and sample index; all advance only on valid samples.
  // The triggering sample is not folded into the baseline: it belongs to the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= ACC_INIT;
      sample_idx_q <= '0;
      peak_q       <= '0;
      width_q      <= '0;
      ts_q         <= '0;
      base_l_q     <= '0;
      hold_q       <= '0;
      emit_q       <= 1'b0;
    end else begin
      emit_q <= 1'b0;
      if (sample_valid) begin
        sample_idx_q <= sample_idx_q + 32'd1;
        unique case (state_q)
          ST_IDLE: begin
            if (above) begin
              state_q  <= ST_PULSE;
              peak_q   <= sample_in;
              width_q  <= 16'd1;
              ts_q     <= sample_idx_q;
              base_l_q <= baseline;
            end else begin
              acc_q <= acc_d;
            end
          end
          ST_PULSE: begin
            if (above) begin
              peak_q  <= max_adc(peak_q, sample_in);
              width_q <= sat_inc16(width_q);
            end else begin
              emit_q  <= 1'b1;
              hold_q  <= HOLD_LOAD;
              state_q <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            hold_q <= hold_q - 16'd1;
            if (hold_q <= 16'd1) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Single-entry event register with handshake, event counter and drop counter.
  // The pulse record (peak_q etc.) is still intact here because the FSM sits in
  // holdoff during the cycle emit_q is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid_q <= 1'b0;
      ev_peak_q  <= '0;
      ev_width_q <= '0;
      ev_ts_q    <= '0;
      ev_count_q <= '0;
      drop_q     <= '0;
    end else begin
      if (emit_q) begin
        if (!ev_valid_q || event_ready) begin
          ev_valid_q <= 1'b1;
          ev_peak_q  <= peak_q - base_l_q;
          ev_width_q <= width_q;
          ev_ts_q    <= ts_q;
          ev_count_q <= ev_count_q + 32'd1;
        end else begin
          drop_q <= sat_inc16(drop_q);
        end
      end else if (ev_valid_q && event_ready) begin
        ev_valid_q <= 1'b0;
      end
      if (clear_counts) begin
        ev_count_q <= '0;
        drop_q     <= '0;
      end
    end
  end

  assign event_valid     = ev_valid_q;
  assign event_peak      = ev_peak_q;
  assign event_width     = ev_width_q;
  assign event_timestamp = ev_ts_q;
  assign event_count     = ev_count_q;
  assign drop_count      = drop_q;
  assign baseline_out    = baseline;

endmodule

// File: tb/tb_pulse_detector.sv
// tb_pulse_detector: table-driven single-pulse vectors, hand-written multi-cycle
// sequences, and a randomized run against a sample-stream reference model.
module tb_pulse_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [11:0] threshold = 12'd100;
  logic        clear_counts = 1'b0;
  logic        event_valid;
  logic        event_ready = 1'b0;
  logic [11:0] event_peak;
  logic [15:0] event_width;
  logic [31:0] event_timestamp;
  logic [31:0] event_count;
  logic [15:0] drop_count;
  logic [11:0] baseline_out;

  int n_checks = 0;
  int n_fail   = 0;

  pulse_detector dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_in       (sample_in),
    .sample_valid    (sample_valid),
    .threshold       (threshold),
    .clear_counts    (clear_counts),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_peak      (event_peak),
    .event_width     (event_width),
    .event_timestamp (event_timestamp),
    .event_count     (event_count),
    .drop_count      (drop_count),
    .baseline_out    (baseline_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int peak;
    int width;
    int ts;
  } rec_t;
  rec_t cap_q[$];

  // records actually handed over (valid && ready at the coming edge)
  always @(negedge clk) begin
    if (rst_n && event_valid && event_ready)
      cap_q.push_back('{int'(event_peak), int'(event_width), int'(event_timestamp)});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (stream-level view) ----------------
  int        m_acc;
  bit [31:0] m_idx;
  bit        m_in_pulse;
  int        m_quiet;
  int        m_peak_run, m_w_run, m_base_run;
  bit [31:0] m_ts_run;
  bit        m_pend;
  int        m_pend_peak, m_pend_width;
  bit [31:0] m_pend_ts;
  bit        m_valid;
  int        m_peak, m_width;
  bit [31:0] m_ts;
  bit [31:0] m_cnt;
  int        m_drop;
  int        m_thr;

  task automatic model_reset();
    m_acc = 2048 * 16; m_idx = 0; m_in_pulse = 0; m_quiet = 0;
    m_peak_run = 0; m_w_run = 0; m_base_run = 0; m_ts_run = 0;
    m_pend = 0; m_pend_peak = 0; m_pend_width = 0; m_pend_ts = 0;
    m_valid = 0; m_peak = 0; m_width = 0; m_ts = 0; m_cnt = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit rdy, input bit clr);
    int base;
    bit above;
    if (m_pend) begin
      if (!m_valid || rdy) begin
        m_valid = 1; m_peak = m_pend_peak; m_width = m_pend_width; m_ts = m_pend_ts;
        m_cnt = m_cnt + 1;
      end else if (m_drop < 65535) begin
        m_drop++;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (clr) begin m_cnt = 0; m_drop = 0; end
    m_pend = 0;
    if (v) begin
      base  = m_acc / 16;
      above = (s > base + m_thr);
      if (m_quiet > 0) begin
        m_quiet--;
      end else if (m_in_pulse) begin
        if (above) begin
          if (s > m_peak_run) m_peak_run = s;
          if (m_w_run < 65535) m_w_run++;
        end else begin
          m_in_pulse = 0; m_pend = 1; m_quiet = 16;
          m_pend_peak = m_peak_run - m_base_run; m_pend_width = m_w_run; m_pend_ts = m_ts_run;
        end
      end else if (above) begin
        m_in_pulse = 1; m_peak_run = s; m_w_run = 1; m_ts_run = m_idx; m_base_run = base;
      end else begin
        m_acc = m_acc + s - base;
      end
      m_idx = m_idx + 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst_n = 1'b0; sample_valid = 1'b0; sample_in = '0;
    event_ready = 1'b0; clear_counts = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cap_q.delete();
    model_reset();
  endtask

  // drive one cycle of inputs; returns 1 time unit after the edge that clocked them
  task automatic step(input logic v, input int s);
    sample_valid = v;
    sample_in    = 12'(s);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int s);
    for (int i = 0; i < n; i++) step(1'b1, s);
  endtask

  typedef struct {
    int thr;
    int n;
    int s0, s1, s2;
    int exp_ev;
    int exp_peak;
    int exp_width;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{100, 3, 2300, 2400, 2250, 1, 352, 3};
    vecs[1] = '{100, 1, 2149, 0,    0,    1, 101, 1};
    vecs[2] = '{100, 1, 2148, 0,    0,    0, 0,   0};
    vecs[3] = '{0,   2, 2049, 2049, 0,    1, 1,   2};
    vecs[4] = '{2047,2, 4095, 4000, 0,    0, 0,   0};
    vecs[5] = '{2046,1, 4095, 0,    0,    1, 2047,1};

    // reset state
    do_reset();
    check("rst_valid", 32'(event_valid), 0);
    check("rst_count", event_count, 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_base", 32'(baseline_out), 2048);
    check("rst_peak", 32'(event_peak), 0);
    check("rst_width", 32'(event_width), 0);
    check("rst_ts", event_timestamp, 0);

    // single-pulse table
    for (int r = 0; r < 6; r++) begin
      do_reset();
      threshold   = 12'(vecs[r].thr);
      event_ready = 1'b1;
      run(64, 2048);
      step(1'b1, vecs[r].s0);
      if (vecs[r].n > 1) step(1'b1, vecs[r].s1);
      if (vecs[r].n > 2) step(1'b1, vecs[r].s2);
      run(5, 2048);
      check($sformatf("tbl%0d_nev", r), 32'(cap_q.size()), 32'(vecs[r].exp_ev));
      check($sformatf("tbl%0d_count", r), event_count, 32'(vecs[r].exp_ev));
      if (vecs[r].exp_ev == 1 && cap_q.size() == 1) begin
        check($sformatf("tbl%0d_peak", r), 32'(cap_q[0].peak), 32'(vecs[r].exp_peak));
        check($sformatf("tbl%0d_width", r), 32'(cap_q[0].width), 32'(vecs[r].exp_width));
        check($sformatf("tbl%0d_ts", r), 32'(cap_q[0].ts), 64);
        check($sformatf("tbl%0d_base", r), 32'(baseline_out), 2048);
      end
    end

    // level-equal stream never triggers; baseline settles onto it
    do_reset();
    threshold = 12'd100; event_ready = 1'b1;
    run(300, 2148);
    check("eq_nev", 32'(cap_q.size()), 0);
    check("eq_valid", 32'(event_valid), 0);
    check("eq_base", 32'(baseline_out), 2148);

    // holdoff: samples 5 and 16 after the end ignored, sample 17 triggers;
    // a clear coinciding with the second emit wins
    do_reset();
    threshold = 12'd100; event_ready = 1'b1;
    run(64, 2048);
    step(1'b1, 2300); step(1'b1, 2400); step(1'b1, 2250); step(1'b1, 2100);
    for (int k = 1; k <= 16; k++) step(1'b1, (k == 5 || k == 16) ? 2400 : 2048);
    check("hold_nev", 32'(cap_q.size()), 1);
    step(1'b1, 2400);
    step(1'b1, 2048);
    clear_counts = 1'b1;
    step(1'b1, 2048);
    clear_counts = 1'b0;
    check("hold_clr_count", event_count, 0);
    check("hold_clr_valid", 32'(event_valid), 1);
    run(3, 2048);
    check("hold_nev2", 32'(cap_q.size()), 2);
    if (cap_q.size() == 2) begin
      check("hold_ts1", 32'(cap_q[0].ts), 64);
      check("hold_ts2", 32'(cap_q[1].ts), 84);
      check("hold_peak2", 32'(cap_q[1].peak), 352);
      check("hold_width2", 32'(cap_q[1].width), 1);
    end

    // backpressure: first held, second dropped, third loads on a same-cycle ready
    do_reset();
    threshold = 12'd100; event_ready = 1'b0;
    run(64, 2048);
    step(1'b1, 2300); step(1'b1, 2400); step(1'b1, 2100);
    run(26, 2048);
    check("bp_valid", 32'(event_valid), 1);
    check("bp_ts_a", event_timestamp, 64);
    step(1'b1, 2500); step(1'b1, 2100);
    step(1'b1, 2048);
    check("bp_drop", 32'(drop_count), 1);
    check("bp_count", event_count, 1);
    check("bp_held_ts", event_timestamp, 64);
    check("bp_held_peak", 32'(event_peak), 352);
    check("bp_held_width", 32'(event_width), 2);
    run(25, 2048);
    check("bp_held_ts2", event_timestamp, 64);
    step(1'b1, 2600); step(1'b1, 2100);
    event_ready = 1'b1;
    step(1'b0, 0);
    event_ready = 1'b0;
    check("bp_c_valid", 32'(event_valid), 1);
    check("bp_c_ts", event_timestamp, 121);
    check("bp_c_peak", 32'(event_peak), 552);
    check("bp_c_count", event_count, 2);
    check("bp_c_drop", 32'(drop_count), 1);
    clear_counts = 1'b1;
    step(1'b0, 0);
    clear_counts = 1'b0;
    check("bp_clr_count", event_count, 0);
    check("bp_clr_drop", 32'(drop_count), 0);

    // sparse sample_valid gives the same record
    do_reset();
    threshold = 12'd100; event_ready = 1'b1;
    for (int i = 0; i < 69; i++) begin
      int v;
      v = (i == 64) ? 2300 : (i == 65) ? 2400 : (i == 66) ? 2250 : (i == 67) ? 2100 : 2048;
      step(1'b0, 0); step(1'b0, 0); step(1'b1, v);
    end
    run(4, 2048);
    check("sparse_nev", 32'(cap_q.size()), 1);
    if (cap_q.size() == 1) begin
      check("sparse_peak", 32'(cap_q[0].peak), 352);
      check("sparse_width", 32'(cap_q[0].width), 3);
      check("sparse_ts", 32'(cap_q[0].ts), 64);
    end

    // reset in the middle of a pulse
    do_reset();
    threshold = 12'd100; event_ready = 1'b0;
    run(64, 2048);
    step(1'b1, 2300); step(1'b1, 2100);
    run(16, 2048);
    run(3, 2100);
    step(1'b1, 2300);
    check("mr_pre_valid", 32'(event_valid), 1);
    check("mr_pre_base", 32'(baseline_out), 2057);
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(event_valid), 0);
    check("mr_count", event_count, 0);
    check("mr_base", 32'(baseline_out), 2048);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cap_q.delete();
    event_ready = 1'b1;
    run(10, 2048);
    step(1'b1, 2300); step(1'b1, 2100);
    run(4, 2048);
    check("mr_nev", 32'(cap_q.size()), 1);
    if (cap_q.size() == 1) begin
      check("mr_ts", 32'(cap_q[0].ts), 10);
      check("mr_peak", 32'(cap_q[0].peak), 252);
    end

    // randomized stream against the model
    do_reset();
    m_thr = int'($urandom_range(40, 150));
    threshold = 12'(m_thr);
    begin
      int pulse_rem = 0;
      int rdy_pct = 100;
      for (int c = 0; c < 4000 && n_fail < 50; c++) begin
        bit v, rdy, clr;
        int s, lvl;
        if (c % 500 == 0) begin
          case ($urandom_range(0, 2))
            0: rdy_pct = 100;
            1: rdy_pct = 50;
            default: rdy_pct = 5;
          endcase
        end
        v   = ($urandom_range(0, 99) < 70);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        clr = ($urandom_range(0, 199) == 0);
        lvl = m_acc / 16 + m_thr;
        if (pulse_rem > 0) begin
          s = lvl + int'($urandom_range(0, 400)) - 20;
          if (v) pulse_rem--;
        end else if ($urandom_range(0, 99) < 5) begin
          pulse_rem = int'($urandom_range(1, 6));
          s = lvl + int'($urandom_range(0, 1));
        end else begin
          s = 2000 + int'($urandom_range(0, 60));
        end
        if (s > 4095) s = 4095;
        if (s < 0) s = 0;
        sample_valid = v; sample_in = 12'(s); event_ready = rdy; clear_counts = clr;
        @(negedge clk);
        check("rnd_valid", 32'(event_valid), 32'(m_valid));
        check("rnd_count", event_count, m_cnt);
        check("rnd_drop", 32'(drop_count), 32'(m_drop));
        check("rnd_base", 32'(baseline_out), 32'(m_acc / 16));
        if (m_valid) begin
          check("rnd_peak", 32'(event_peak), 32'(m_peak));
          check("rnd_width", 32'(event_width), 32'(m_width));
          check("rnd_ts", event_timestamp, m_ts);
        end
        model_step(v, s, rdy, clr);
        @(posedge clk);
        #1;
      end
    end
    clear_counts = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
